alu_control_seq: RTL
====================

Name: alu_control_seq

Overview:
- Registered, parametrised successor to the combinational ALU control decoder.
- Decodes {ALUOp, ALUFunction} into an ALU operation code with one cycle of latency.
- Adds multi-cycle MULT/DIV sequencing: start pulse, busy counter and a stall handshake toward the datapath.
- Sits between the main control unit / instruction field and the ALU plus a separate mult/div unit with HI/LO registers.

Parameters:
- ALUOP_WIDTH, 3, width of ALUOp from the control unit.
- FUNCT_WIDTH, 6, width of the instruction function field.
- OP_WIDTH, 4, width of the ALU operation code.
- MUL_CYCLES, 4, mult/div unit busy cycles for MULT (legal range 1..255).
- DIV_CYCLES, 32, mult/div unit busy cycles for DIV (legal range 1..255).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- valid_i  input  1  instruction present on ALUOp/ALUFunction this cycle.
- ALUOp  input  ALUOP_WIDTH  operation class from the control unit.
- ALUFunction  input  FUNCT_WIDTH  instruction function field.
- stall_o  output  1  combinational; instruction not accepted this cycle, hold inputs.
- alu_operation_o  output  OP_WIDTH  registered ALU operation code.
- op_valid_o  output  1  one-cycle pulse per accepted instruction.
- illegal_o  output  1  accepted instruction did not decode (coincides with op_valid_o).
- md_start_o  output  1  one-cycle start pulse to the mult/div unit.
- md_op_o  output  1  0 = MULT, 1 = DIV; valid with md_start_o, held until the next start.
- md_busy_o  output  1  mult/div sequence in progress.
- md_done_o  output  1  one-cycle pulse in the last busy cycle.
- hilo_read_o  output  1  accepted MFHI/MFLO; pulses with op_valid_o.
- hilo_sel_o  output  1  1 = HI, 0 = LO; valid with hilo_read_o.

Behaviour:
- Decode table (ALUOp_funct -> code):
  - R-type, ALUOp=111: AND 100100->0000, OR 100101->0001, NOR 100111->0010, ADD 100000->0011, SUB 100010->0100, SLL 000000->0101, SRL 000010->0110, SLT 101010->1000.
  - I-type, funct ignored: ANDI 010->0000, ORI 101->0001, ADDI 100->0011, LW/SW 011->0011, BEQ 110->0100, BNE 001->0100, LUI 000->0111.
  - Multi-cycle R-type (ALU code 1001): MULT 011000, DIV 011010, MFHI 010000, MFLO 010010.
  - Anything else: code 1001 with illegal_o=1.
- Acceptance: an instruction is accepted at a posedge when valid_i=1 and stall_o=0.
  - Registered outputs update the following cycle (latency 1); op_valid_o pulses for exactly one cycle.
  - With no acceptance, op_valid_o, illegal_o and hilo_read_o are 0, and alu_operation_o holds its previous value.
- FSM states: IDLE, BUSY.
  - IDLE: accepting MULT or DIV pulses md_start_o next cycle, sets md_op_o, loads the 8-bit counter with CYCLES-1 and goes to BUSY; md_busy_o=1 from that same cycle.
  - BUSY: counter decrements each cycle. When the counter is 0, md_done_o=1 that cycle, then the FSM returns to IDLE and md_busy_o drops. CYCLES=1 gives one busy cycle with start and done coincident.
- stall_o = valid_i and (state == BUSY) and the input is MULT/DIV/MFHI/MFLO.
  - Other instructions are accepted during BUSY and decode normally.
  - A conflicting instruction arriving in the md_done_o cycle is still stalled; it is accepted the next cycle.
- stall_o is never asserted when valid_i=0 or the FSM is in IDLE.
- Reset, asynchronous at any time including mid-BUSY:
  - FSM to IDLE, counter 0.
  - alu_operation_o=1001; all other outputs 0.
  - An in-flight sequence is abandoned with no md_done_o.
- Counter arithmetic is unsigned, 8 bits wide, and never underflows.

Test Plan:
- Reset, then R-type ADD (111_100000) with valid_i=1 -> next cycle alu_operation_o=0011, op_valid_o=1 for one cycle; alu_operation_o still 0011 with valid_i=0 afterward.
- ALUOp=101 with any funct, then ALUOp=111 funct=111111 -> 0001 with illegal_o=0, then 1001 with illegal_o=1.
- MULT with MUL_CYCLES=4 -> md_start_o and md_op_o=0 one cycle later; md_busy_o high for exactly 4 cycles; md_done_o in the 4th; FSM back in IDLE.
- DIV accepted, then MFLO presented during BUSY -> stall_o=1 every busy cycle including the done cycle. MFLO is accepted the cycle after md_done_o: hilo_read_o=1, hilo_sel_o=0 next cycle.
- During MULT BUSY, present SUB (111_100010) -> stall_o=0, alu_operation_o=0100 next cycle, busy count unaffected.
- Assert reset 2 cycles into DIV BUSY -> md_busy_o=0 and alu_operation_o=1001 immediately, no md_done_o; a fresh MULT after release is accepted without stall.

Source files
------------

// File: rtl/alu_control_seq.sv
// Registered ALU control decoder with MULT/DIV sequencing and a stall handshake
// that holds off HI/LO-dependent instructions while the mult/div unit is busy.
module alu_control_seq #(
  parameter int unsigned ALUOP_WIDTH = 3,
  parameter int unsigned FUNCT_WIDTH = 6,
  parameter int unsigned OP_WIDTH    = 4,
  parameter int unsigned MUL_CYCLES  = 4,
  parameter int unsigned DIV_CYCLES  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   valid_i,
  input  logic [ALUOP_WIDTH-1:0] ALUOp,
  input  logic [FUNCT_WIDTH-1:0] ALUFunction,
  output logic                   stall_o,
  output logic [OP_WIDTH-1:0]    alu_operation_o,
  output logic                   op_valid_o,
  output logic                   illegal_o,
  output logic                   md_start_o,
  output logic                   md_op_o,
  output logic                   md_busy_o,
  output logic                   md_done_o,
  output logic                   hilo_read_o,
  output logic                   hilo_sel_o
);

  localparam int unsigned CNT_WIDTH = 8;
  localparam logic [CNT_WIDTH-1:0] MUL_LOAD = CNT_WIDTH'(MUL_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] DIV_LOAD = CNT_WIDTH'(DIV_CYCLES - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [OP_WIDTH-1:0] OP_AND = OP_WIDTH'(4'b0000);
  localparam logic [OP_WIDTH-1:0] OP_OR  = OP_WIDTH'(4'b0001);
  localparam logic [OP_WIDTH-1:0] OP_NOR = OP_WIDTH'(4'b0010);
  localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(4'b0011);
  localparam logic [OP_WIDTH-1:0] OP_SUB = OP_WIDTH'(4'b0100);
  localparam logic [OP_WIDTH-1:0] OP_SLL = OP_WIDTH'(4'b0101);
  localparam logic [OP_WIDTH-1:0] OP_SRL = OP_WIDTH'(4'b0110);
  localparam logic [OP_WIDTH-1:0] OP_LUI = OP_WIDTH'(4'b0111);
  localparam logic [OP_WIDTH-1:0] OP_SLT = OP_WIDTH'(4'b1000);
  localparam logic [OP_WIDTH-1:0] OP_MD  = OP_WIDTH'(4'b1001);

  localparam logic [ALUOP_WIDTH-1:0] AOP_R    = ALUOP_WIDTH'(3'b111);
  localparam logic [ALUOP_WIDTH-1:0] AOP_ANDI = ALUOP_WIDTH'(3'b010);
  localparam logic [ALUOP_WIDTH-1:0] AOP_ORI  = ALUOP_WIDTH'(3'b101);
  localparam logic [ALUOP_WIDTH-1:0] AOP_ADDI = ALUOP_WIDTH'(3'b100);
  localparam logic [ALUOP_WIDTH-1:0] AOP_MEM  = ALUOP_WIDTH'(3'b011);
  localparam logic [ALUOP_WIDTH-1:0] AOP_BEQ  = ALUOP_WIDTH'(3'b110);
  localparam logic [ALUOP_WIDTH-1:0] AOP_BNE  = ALUOP_WIDTH'(3'b001);
  localparam logic [ALUOP_WIDTH-1:0] AOP_LUI  = ALUOP_WIDTH'(3'b000);

  localparam logic [FUNCT_WIDTH-1:0] F_AND  = FUNCT_WIDTH'(6'b100100);
  localparam logic [FUNCT_WIDTH-1:0] F_OR   = FUNCT_WIDTH'(6'b100101);
  localparam logic [FUNCT_WIDTH-1:0] F_NOR  = FUNCT_WIDTH'(6'b100111);
  localparam logic [FUNCT_WIDTH-1:0] F_ADD  = FUNCT_WIDTH'(6'b100000);
  localparam logic [FUNCT_WIDTH-1:0] F_SUB  = FUNCT_WIDTH'(6'b100010);
  localparam logic [FUNCT_WIDTH-1:0] F_SLL  = FUNCT_WIDTH'(6'b000000);
  localparam logic [FUNCT_WIDTH-1:0] F_SRL  = FUNCT_WIDTH'(6'b000010);
  localparam logic [FUNCT_WIDTH-1:0] F_SLT  = FUNCT_WIDTH'(6'b101010);
  localparam logic [FUNCT_WIDTH-1:0] F_MULT = FUNCT_WIDTH'(6'b011000);
  localparam logic [FUNCT_WIDTH-1:0] F_DIV  = FUNCT_WIDTH'(6'b011010);
  localparam logic [FUNCT_WIDTH-1:0] F_MFHI = FUNCT_WIDTH'(6'b010000);
  localparam logic [FUNCT_WIDTH-1:0] F_MFLO = FUNCT_WIDTH'(6'b010010);

  logic [0:0]           r_state;
  logic [0:0]           w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;

  logic [OP_WIDTH-1:0]  w_code;
  logic                 w_illegal;
  logic                 w_is_md;
  logic                 w_md_op;
  logic                 w_is_hilo;
  logic                 w_hilo_sel;
  logic                 w_accept;

  logic [OP_WIDTH-1:0]  r_alu_op;
  logic                 r_op_valid;
  logic                 r_illegal;
  logic                 r_md_start;
  logic                 r_md_op;
  logic                 r_hilo_read;
  logic                 r_hilo_sel;

  // Instruction decode; mult/div-unit instructions share the 1001 code
  always_comb begin
    w_code     = OP_MD;
    w_illegal  = 1'b0;
    w_is_md    = 1'b0;
    w_md_op    = 1'b0;
    w_is_hilo  = 1'b0;
    w_hilo_sel = 1'b0;
    if (ALUOp == AOP_R) begin
      case (ALUFunction)
        F_AND:   w_code = OP_AND;
        F_OR:    w_code = OP_OR;
        F_NOR:   w_code = OP_NOR;
        F_ADD:   w_code = OP_ADD;
        F_SUB:   w_code = OP_SUB;
        F_SLL:   w_code = OP_SLL;
        F_SRL:   w_code = OP_SRL;
        F_SLT:   w_code = OP_SLT;
        F_MULT:  w_is_md = 1'b1;
        F_DIV: begin
          w_is_md = 1'b1;
          w_md_op = 1'b1;
        end
        F_MFHI: begin
          w_is_hilo  = 1'b1;
          w_hilo_sel = 1'b1;
        end
        F_MFLO:  w_is_hilo = 1'b1;
        default: w_illegal = 1'b1;
      endcase
    end else begin
      case (ALUOp)
        AOP_ANDI: w_code = OP_AND;
        AOP_ORI:  w_code = OP_OR;
        AOP_ADDI: w_code = OP_ADD;
        AOP_MEM:  w_code = OP_ADD;
        AOP_BEQ:  w_code = OP_SUB;
        AOP_BNE:  w_code = OP_SUB;
        AOP_LUI:  w_code = OP_LUI;
        default:  w_illegal = 1'b1;
      endcase
    end
  end

  assign stall_o  = valid_i && (r_state == S_BUSY) && (w_is_md || w_is_hilo);
  assign w_accept = valid_i && !stall_o;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Sequencer: load CYCLES-1 on start, leave BUSY after the cycle where the count is 0
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_is_md) begin
          w_state_nxt = S_BUSY;
          w_cnt_nxt   = w_md_op ? DIV_LOAD : MUL_LOAD;
        end
      end
      S_BUSY: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_WIDTH'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_alu_op    <= OP_MD;
      r_op_valid  <= 1'b0;
      r_illegal   <= 1'b0;
      r_md_start  <= 1'b0;
      r_md_op     <= 1'b0;
      r_hilo_read <= 1'b0;
      r_hilo_sel  <= 1'b0;
    end else begin
      r_op_valid  <= w_accept;
      r_illegal   <= w_accept && w_illegal;
      r_md_start  <= w_accept && w_is_md;
      r_hilo_read <= w_accept && w_is_hilo;
      if (w_accept) r_alu_op <= w_code;
      if (w_accept && w_is_md) r_md_op <= w_md_op;
      if (w_accept && w_is_hilo) r_hilo_sel <= w_hilo_sel;
    end
  end

  assign alu_operation_o = r_alu_op;
  assign op_valid_o      = r_op_valid;
  assign illegal_o       = r_illegal;
  assign md_start_o      = r_md_start;
  assign md_op_o         = r_md_op;
  assign hilo_read_o     = r_hilo_read;
  assign hilo_sel_o      = r_hilo_sel;
  assign md_busy_o       = (r_state == S_BUSY);
  assign md_done_o       = (r_state == S_BUSY) && (r_cnt == '0);

endmodule
